button_event_conditioner: RTL and testbench



---
 rtl/button_event_conditioner.sv | 132 +++++++++++++
 tb/tb_button_event_conditioner.sv | 135 +++++++++++++
 2 files changed

// File: rtl/button_event_conditioner.sv
// Button front-end: 2-FF sync, per-channel debounce, press/release
// pulses and optional auto-repeat, all gated by ena.
module button_event_conditioner #(
    parameter int             N_BTN           = 4,
    parameter int             DEBOUNCE_CYCLES = 16,
    parameter int             REPEAT_DELAY    = 64,
    parameter int             REPEAT_RATE     = 16,
    parameter logic [N_BTN-1:0] REPEAT_MASK   = 4'b1100,
    parameter int             CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_event,
    output logic [N_BTN-1:0] btn_release
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HELD = 2'd1;
    localparam logic [1:0] S_DLY  = 2'd2;
    localparam logic [1:0] S_RPT  = 2'd3;

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_RATE - 1);

    logic [N_BTN-1:0] sync1_q, sync2_q;
    logic [N_BTN-1:0] stab_q, stab_d;
    logic [N_BTN-1:0] level_q, level_d;
    logic [N_BTN-1:0] event_q, event_d;
    logic [N_BTN-1:0] rel_q, rel_d;
    logic [CNT_W-1:0] dcnt_q [N_BTN];
    logic [CNT_W-1:0] dcnt_d [N_BTN];
    logic [CNT_W-1:0] tmr_q  [N_BTN];
    logic [CNT_W-1:0] tmr_d  [N_BTN];
    logic [1:0]       st_q   [N_BTN];
    logic [1:0]       st_d   [N_BTN];

    // stab_q is the internal debounced level; btn_level is its registered
    // copy, so stab_q vs level_q marks the edge one cycle before it shows.
    // Debounce, edge detect and per-channel press/repeat/release FSM.
    always_comb begin
        level_d = stab_q;
        stab_d  = stab_q;
        event_d = '0;
        rel_d   = '0;
        for (int i = 0; i < N_BTN; i++) begin
            dcnt_d[i] = '0;
            tmr_d[i]  = tmr_q[i];
            st_d[i]   = st_q[i];
            if (sync2_q[i] != stab_q[i]) begin
                if (dcnt_q[i] == DB_LAST) begin
                    stab_d[i] = sync2_q[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + 1'b1;
                end
            end
            if (!ena) begin
                st_d[i]  = S_IDLE;
                tmr_d[i] = '0;
            end else begin
                unique case (st_q[i])
                    S_IDLE: begin
                        tmr_d[i] = '0;
                        if (stab_q[i] && !level_q[i]) begin
                            event_d[i] = 1'b1;
                            st_d[i]    = REPEAT_MASK[i] ? S_DLY : S_HELD;
                        end
                    end
                    S_HELD: begin
                        if (!stab_q[i] && level_q[i]) begin
                            rel_d[i] = 1'b1;
                            st_d[i]  = S_IDLE;
                        end
                    end
                    S_DLY, S_RPT: begin
                        if (!stab_q[i] && level_q[i]) begin
                            rel_d[i] = 1'b1;
                            st_d[i]  = S_IDLE;
                            tmr_d[i] = '0;
                        end else if (tmr_q[i] ==
                                     ((st_q[i] == S_DLY) ? DLY_LAST
                                                         : RPT_LAST)) begin
                            event_d[i] = 1'b1;
                            tmr_d[i]   = '0;
                            st_d[i]    = S_RPT;
                        end else begin
                            tmr_d[i] = tmr_q[i] + 1'b1;
                        end
                    end
                    default: st_d[i] = S_IDLE;
                endcase
            end
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            stab_q  <= '0;
            level_q <= '0;
            event_q <= '0;
            rel_q   <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                dcnt_q[i] <= '0;
                tmr_q[i]  <= '0;
                st_q[i]   <= S_IDLE;
            end
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            stab_q  <= stab_d;
            level_q <= level_d;
            event_q <= event_d;
            rel_q   <= rel_d;
            for (int i = 0; i < N_BTN; i++) begin
                dcnt_q[i] <= dcnt_d[i];
                tmr_q[i]  <= tmr_d[i];
                st_q[i]   <= st_d[i];
            end
        end
    end

    assign btn_level   = level_q;
    assign btn_event   = event_q;
    assign btn_release = rel_q;

endmodule

// File: tb/tb_button_event_conditioner.sv
// Directed bench for button_event_conditioner (DB=4, delay=8, rate=3).
// Per-edge outputs are logged into bit masks and compared to hand values.
module tb_button_event_conditioner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [3:0] btn_raw;
    logic [3:0] btn_level, btn_event, btn_release;

    int n_chk = 0;
    int n_err = 0;

    logic [63:0] lm [4];
    logic [63:0] em [4];
    logic [63:0] rm [4];
    logic [63:0] x;

    button_event_conditioner #(
        .N_BTN(4), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(8),
        .REPEAT_RATE(3), .REPEAT_MASK(4'b1100), .CNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .btn_raw(btn_raw),
        .btn_level(btn_level), .btn_event(btn_event),
        .btn_release(btn_release)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // Drive btn_raw=m; next posedge is edge 0. Drop raw after edge hold-1.
    task automatic run(input logic [3:0] m, input int hold, input int n);
        for (int c = 0; c < 4; c++) begin
            lm[c] = '0; em[c] = '0; rm[c] = '0;
        end
        btn_raw = m;
        for (int e = 0; e < n; e++) begin
            @(posedge clk);
            #1;
            for (int c = 0; c < 4; c++) begin
                lm[c][e] = btn_level[c];
                em[c][e] = btn_event[c];
                rm[c][e] = btn_release[c];
            end
            if (e == hold - 1) btn_raw = '0;
        end
    endtask

    function automatic logic [63:0] span(input int a, input int b);
        logic [63:0] r = '0;
        for (int k = a; k <= b; k++) r[k] = 1'b1;
        return r;
    endfunction

    function automatic logic [63:0] rpt(input int last);
        logic [63:0] r = '0;
        r[6] = 1'b1;
        for (int k = 14; k <= last; k += 3) r[k] = 1'b1;
        return r;
    endfunction

    initial begin
        rst_n = 1'b0; ena = 1'b1; btn_raw = '0;
        #1;
        chk("rst_level", 64'(btn_level), 64'd0);
        chk("rst_event", 64'(btn_event), 64'd0);
        chk("rst_rel", 64'(btn_release), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        run(4'b0001, 3, 12);
        chk("glitch_level", lm[0], 64'd0);
        chk("glitch_event", em[0], 64'd0);
        chk("glitch_rel", rm[0], 64'd0);

        run(4'b0001, 30, 45);
        chk("press0_level", lm[0], span(6, 35));
        chk("press0_event", em[0], span(6, 6));
        chk("press0_rel", rm[0], span(36, 36));

        run(4'b0100, 30, 45);
        chk("rpt2_level", lm[2], span(6, 35));
        chk("rpt2_event", em[2], rpt(35));
        chk("rpt2_rel", rm[2], span(36, 36));

        run(4'b1001, 12, 25);
        chk("sim0_event", em[0], span(6, 6));
        chk("sim3_event", em[3], rpt(17));
        chk("sim0_rel", rm[0], span(18, 18));
        chk("sim3_rel", rm[3], span(18, 18));

        ena = 1'b0;
        run(4'b0010, 100, 12);
        chk("ena0_level", lm[1], span(6, 11));
        chk("ena0_event", em[1], 64'd0);
        ena = 1'b1;
        run(4'b0010, 100, 10);
        chk("ena_held_event", em[1], 64'd0);
        run(4'b0000, 0, 12);
        chk("ena_rel_level", lm[1], span(0, 5));
        chk("ena_rel_none", rm[1], 64'd0);
        run(4'b0010, 100, 10);
        chk("repress_event", em[1], span(6, 6));
        run(4'b0000, 0, 12);
        chk("repress_rel", rm[1], span(6, 6));

        run(4'b0100, 1000, 20);
        #1 rst_n = 1'b0;
        #1;
        x = 64'(btn_level);
        chk("midrst_level", x, 64'd0);
        chk("midrst_event", 64'(btn_event), 64'd0);
        chk("midrst_rel", 64'(btn_release), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run(4'b0100, 1000, 25);
        chk("postrst_level", lm[2], span(6, 24));
        chk("postrst_event", em[2], rpt(24));
        btn_raw = '0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
